chain_score_acc: RTL

Predecessor-scoring and max-accumulate stage of the DSA chaining datapath. It takes candidate predecessor pairs (j → i) for one anchor i at a time and computes gap `dd = |dr − dq|`. It sends `dd` to the downstream integer-log2 pipeline and consumes the returned log2 to form the gap cost. It then tracks the best chained score `f[i]` and best predecessor index per anchor, emitting one result per anchor group.

---
 rtl/chain_pkg.sv | 37 +++
 rtl/delay_line.sv | 37 +++
 rtl/chain_score_acc.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/chain_pkg.sv
// Shared types, saturation limits and side-pipe payload for the DSA chaining
// predecessor-scoring datapath.
package chain_pkg;

  localparam int IDX_W = 16;

  typedef logic signed [31:0] score_t;
  typedef logic signed [31:0] coord_t;
  typedef logic [IDX_W-1:0]   idx_t;

  localparam score_t SCORE_MAX = 32'sh7FFF_FFFF;
  localparam score_t SCORE_MIN = 32'sh8000_0000;

  typedef enum logic {S_IDLE, S_ACC} acc_state_t;

  // Everything stage B needs about a beat, delayed to line up with lg_in.
  typedef struct packed {
    logic        ok;
    logic        first;
    logic        last;
    logic        nopred;
    logic [7:0]  qspan;
    score_t      min_d;
    logic [31:0] lin;
    score_t      fj;
    idx_t        j;
    logic        dd_zero;
  } pipe_t;

  function automatic score_t sat_add(input score_t a, input score_t b);
    logic [32:0] s;
    s = {a[31], a} + {b[31], b};
    if (s[32] != s[31]) return s[32] ? SCORE_MIN : SCORE_MAX;
    return score_t'(s[31:0]);
  endfunction

endpackage

// File: rtl/delay_line.sv
// Fixed-depth shift register with a per-stage valid bit and synchronous clear
// of the valid bits only.
module delay_line #(
  parameter int DEPTH = 5,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic [DEPTH-1:0] r_valid;
  logic [WIDTH-1:0] r_data [DEPTH];

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_valid <= '0;
    end else begin
      r_valid[0] <= i_valid;
      for (int s = 1; s < DEPTH; s++) r_valid[s] <= r_valid[s-1];
    end
  end

  // NOTE: payload storage has no reset; the valid bits alone decide whether a
  // stage means anything, so clearing the data would only cost reset fan-out.
  always_ff @(posedge clk) begin
    r_data[0] <= i_data;
    for (int s = 1; s < DEPTH; s++) r_data[s] <= r_data[s-1];
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_data  = r_data[DEPTH-1];

endmodule

// File: rtl/chain_score_acc.sv
// Scores predecessor candidates (j -> i) with a linear + log2 gap cost and keeps
// the best chained score and predecessor per anchor group.
module chain_score_acc
  import chain_pkg::*;
#(
  parameter int LOG_LAT = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_nopred,
  input  logic        in_last,
  input  coord_t      in_dq,
  input  coord_t      in_dr,
  input  score_t      in_fj,
  input  idx_t        in_j,
  input  logic [7:0]  in_qspan,
  input  logic [7:0]  cfg_avg_qspan,
  input  logic [15:0] cfg_gap_coef,
  input  logic [31:0] cfg_max_dist,
  input  logic [31:0] cfg_bw,
  output logic [31:0] lg_v,
  input  logic [4:0]  lg_in,
  output logic        out_valid,
  output score_t      out_score,
  output idx_t        out_best_j,
  output logic        out_has_pred
);

  // ---------------- Stage A: gap, linear cost, acceptance ----------------
  logic [31:0] w_diff, w_dd;
  logic [47:0] w_prod;
  score_t      w_min_d, w_avg;
  logic        w_ok;
  pipe_t       w_a_pay;
  logic        r_first_in;
  logic        r_a_valid;
  pipe_t       r_a_pay;

  // NOTE: every signal written here gets a value before any branch, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    w_diff  = in_dr - in_dq;
    w_dd    = w_diff[31] ? (32'd0 - w_diff) : w_diff;
    w_prod  = 48'(w_dd) * 48'(cfg_gap_coef);
    w_avg   = score_t'({24'd0, cfg_avg_qspan});
    w_min_d = (in_dq < in_dr) ? in_dq : in_dr;
    if (w_avg < w_min_d) w_min_d = w_avg;
    w_ok = (in_dq > 32'sd0) && (in_dr > 32'sd0) &&
           ($unsigned(in_dq) <= cfg_max_dist) && ($unsigned(in_dr) <= cfg_max_dist) &&
           (w_dd <= cfg_bw) && !in_nopred;
    w_a_pay = '{ok: w_ok, first: r_first_in, last: in_last, nopred: in_nopred,
                qspan: in_qspan, min_d: w_min_d, lin: w_prod[47:16], fj: in_fj,
                j: in_j, dd_zero: (w_dd == 32'd0)};
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_valid  <= 1'b0;
      r_first_in <= 1'b1;
      lg_v       <= '0;
    end else begin
      r_a_valid <= in_valid;
      if (in_valid) begin
        r_first_in <= in_last || in_nopred;
        lg_v       <= w_dd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid) r_a_pay <= w_a_pay;
  end

  // ---------------- Side pipe aligned with the external log2 -------------
  logic  w_p_valid;
  pipe_t w_p;

  delay_line #(.DEPTH(LOG_LAT), .WIDTH($bits(pipe_t))) u_side_pipe (
    .clk     (clk),
    .i_clr   (reset),
    .i_valid (r_a_valid),
    .i_data  (r_a_pay),
    .o_valid (w_p_valid),
    .o_data  (w_p)
  );

  // ---------------- Stage B: full score and saturated candidate ----------
  logic [4:0] w_log_dd;
  score_t     w_sc, w_cand;
  logic       r_b_valid, r_b_ok, r_b_first, r_b_close;
  logic [7:0] r_b_qspan;
  score_t     r_b_cand;
  idx_t       r_b_j;

  always_comb begin
    w_log_dd = w_p.dd_zero ? 5'd0 : lg_in;
    w_sc     = w_p.min_d - score_t'(w_p.lin) - score_t'({27'd0, w_log_dd >> 1});
    w_cand   = sat_add(w_p.fj, w_sc);
  end

  always_ff @(posedge clk) begin
    if (reset) r_b_valid <= 1'b0;
    else       r_b_valid <= w_p_valid;
  end

  always_ff @(posedge clk) begin
    if (w_p_valid) begin
      r_b_ok    <= w_p.ok;
      r_b_first <= w_p.first;
      r_b_close <= w_p.last || w_p.nopred;
      r_b_qspan <= w_p.qspan;
      r_b_cand  <= w_cand;
      r_b_j     <= w_p.j;
    end
  end

  // ---------------- Accumulate FSM ----------------------------------------
  acc_state_t r_state, w_state_nxt;
  score_t     r_best, w_base_best, w_post_best;
  idx_t       r_best_j, w_base_j, w_post_j;
  logic       r_has, w_base_has, w_post_has, w_open, w_take, w_close;

  always_comb begin
    w_state_nxt = r_state;
    w_open      = (r_state == S_IDLE) || r_b_first;
    w_base_best = w_open ? score_t'({24'd0, r_b_qspan}) : r_best;
    w_base_j    = w_open ? idx_t'(0) : r_best_j;
    w_base_has  = w_open ? 1'b0 : r_has;
    // Strict compare: an equal candidate never displaces an earlier j.
    w_take      = r_b_ok && (r_b_cand > w_base_best);
    w_post_best = w_take ? r_b_cand : w_base_best;
    w_post_j    = w_take ? r_b_j    : w_base_j;
    w_post_has  = w_take || w_base_has;
    w_close     = r_b_valid && r_b_close;
    if (r_b_valid) w_state_nxt = r_b_close ? S_IDLE : S_ACC;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      out_valid    <= 1'b0;
      out_score    <= '0;
      out_best_j   <= '0;
      out_has_pred <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      out_valid <= w_close;
      if (w_close) begin
        out_score    <= w_post_best;
        out_best_j   <= w_post_j;
        out_has_pred <= w_post_has;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_b_valid) begin
      r_best   <= w_post_best;
      r_best_j <= w_post_j;
      r_has    <= w_post_has;
    end
  end

endmodule
